rc4_stream_xor: RTL and testbench
=================================

// Module: rc4_stream_xor
// PURPOSE
//   Parametrised RC4 cipher engine: KSA over a variable-length key, then PRGA.
//   Each keystream byte is XORed with one streamed data byte.
//   Replaces fixed-length keystream-dump cores with a valid/ready byte stream
//   of unbounded length, an abort input and a configurable key length.
//   Sits between the key-load logic and the byte-stream datapath.
// PARAMETERS
//   KEY_MAX_BYTES  16   max key length in bytes (1..256); sets key port width
//   DROP_N         768  keystream bytes discarded before output (RC4_DROP_EN only)
// PORTS
//   clk        in   1                 clock, all logic on rising edge
//   rst        in   1                 synchronous active-high reset
//   start      in   1                 load key and begin KSA; honoured only in IDLE
//   abort      in   1                 return to IDLE from any state next cycle
//   key        in   KEY_MAX_BYTES*8   key byte n at key[8n+:8]
//   key_length in   9                 key length in bytes (1..KEY_MAX_BYTES)
//   busy       out  1                 high in INIT/KSA (and DROP)
//   ks_ready   out  1                 high in PRGA: engine accepts data
//   key_err    out  1                 1-cycle pulse: start with key_length==0
//   in_data    in   8                 plaintext/ciphertext byte
//   in_valid   in   1                 in_data valid
//   in_ready   out  1                 in_data accepted when in_valid&in_ready
//   out_data   out  8                 in_data XOR keystream byte
//   out_valid  out  1                 out_data valid
//   out_ready  in   1                 sink accepts out_data
// BEHAVIOUR
//   Reset: state=IDLE; busy, ks_ready, key_err, in_ready, out_valid = 0; out_data = 0; i=j=0.
//   States: IDLE -> INIT -> KSA -> [DROP] -> PRGA. abort or rst forces IDLE from any state.
//   State contents, key, i, j are left stale; out_valid clears.
//   IDLE: start=1 with key_length==0 -> key_err pulse, stay IDLE.
//   Otherwise key and length are latched; length is clamped to KEY_MAX_BYTES.
//   start outside IDLE is ignored.
//   INIT: 256 cycles, S[n]=n, one entry per cycle.
//   KSA: 256 cycles, one per n.
//   j = j + S[n] + key[n mod len] (mod 256); swap S[n], S[j]. i,j cleared on exit.
//   Total: start at edge 0 -> ks_ready high from edge 513 (no DROP).
//   PRGA, two-phase per byte:
//     STEP (needs in_valid & out skid slot free): in_ready=1 for that cycle, byte latched;
//       i=i+1; j=j+S[i]; swap S[i],S[j].
//     EMIT: out_data = latched ^ S[(S[i]+S[j]) mod 256]; out_valid=1.
//       Held stable until out_ready.
//       STEP may overlap the out_ready cycle.
//       Peak throughput: 1 byte / 2 cycles.
//   Backpressure: out_valid & !out_ready stalls; no keystream byte is skipped or duplicated.
//   Indices, sums and j wrap mod 256; key index wraps mod latched length.
//   abort same cycle as start in IDLE: abort wins, nothing latched.
//   rst same cycle as anything: rst wins.
//   Keystream continues indefinitely; a new key needs abort then start.
// CONFIGURATION
//   RC4_DROP_EN defined: DROP state after KSA runs DROP_N PRGA steps, 1 per cycle.
//     busy stays 1 and output is discarded; ks_ready rises DROP_N cycles later (edge 513+DROP_N).
//   RC4_DROP_EN undefined: no DROP state, DROP_N unused; first PRGA byte is keystream byte 0.
// TESTING
//   1 Key "Key" (key[23:0]=0x79654B, len 3), in "Plaintext" -> out BB F3 16 E8 D9 40 AF 0A D3.
//     ks_ready at edge 513.
//   2 Key "Secret", len 6, in "Attack at dawn"
//     -> out 45 A0 1F 64 5F C3 5B 38 35 52 54 4B 9B F5.
//   3 Key 01 02 03 04 05, in 16 x 00, out_ready toggled randomly
//     -> out b2 39 63 05 f0 3d c0 27 cc c3 52 4a 0a 11 18 a8; no drop or duplicate.
//   4 start with key_length=0 -> key_err one cycle, busy stays 0.
//     key_length=300 with KEY_MAX_BYTES=16 -> behaves as len 16.
//   5 abort mid-KSA (cycle 300) and mid-PRGA with out_valid=1
//     -> IDLE next cycle, out_valid=0.
//     Restart with "Wiki", in "pedia" -> 10 21 BF 04 20.
//   6 RC4_DROP_EN, DROP_N=768, key 01 02 03 04 05 -> ks_ready at edge 1281.
//     First 16 out bytes (in=00) equal RFC 6229 offset-768 row.

Source files
------------

// File: rtl/rc4_stream_xor.sv
`default_nettype none
// ============================================================================
// Module   : rc4_stream_xor
// Brief    : RC4 engine (INIT, KSA over a variable-length key, PRGA) that XORs
//            one keystream byte onto each byte of a valid/ready stream.
//            Define RC4_DROP_EN to discard the first DROP_N keystream bytes.
// Revision : 1.0 - initial release
// ============================================================================
module rc4_stream_xor #(
    parameter int KEY_MAX_BYTES = 16,
    parameter int DROP_N        = 768
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       abort,
    input  logic [KEY_MAX_BYTES*8-1:0] key,
    input  logic [8:0]                 key_length,
    output logic                       busy,
    output logic                       ks_ready,
    output logic                       key_err,
    input  logic [7:0]                 in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [7:0]                 out_data,
    output logic                       out_valid,
    input  logic                       out_ready
);

    localparam int         c_KIDX_W  = (KEY_MAX_BYTES > 1) ? $clog2(KEY_MAX_BYTES) : 1;
    localparam logic [8:0] c_LEN_MAX = 9'(KEY_MAX_BYTES);

    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_INIT = 3'd1;
    localparam logic [2:0] c_ST_KSA  = 3'd2;
    localparam logic [2:0] c_ST_PRGA = 3'd3;
`ifdef RC4_DROP_EN
    localparam logic [2:0] c_ST_DROP = 3'd4;
    localparam int         c_DROP_W  = (DROP_N > 1) ? $clog2(DROP_N) : 1;
    localparam logic [c_DROP_W-1:0] c_DROP_LAST = c_DROP_W'(DROP_N - 1);
`else
    localparam int         c_drop_n_unused = DROP_N;
`endif

    logic [2:0]          r_state;
    logic [7:0]          r_s [256];
    logic [7:0]          r_key [KEY_MAX_BYTES];
    logic [8:0]          r_len;
    logic [c_KIDX_W-1:0] r_kidx;
    logic [7:0]          r_n;
    logic [7:0]          r_i;
    logic [7:0]          r_j;
    logic                r_phase;      // 0: waiting to step, 1: keystream byte ready to emit
    logic [7:0]          r_data;
    logic                r_busy;
    logic                r_ks_ready;
    logic                r_key_err;
    logic                r_out_valid;
    logic [7:0]          r_out_data;
`ifdef RC4_DROP_EN
    logic [c_DROP_W-1:0] r_drop_cnt;
`endif

    logic [8:0] w_len;
    logic       w_load;
    logic       w_slot_free;
    logic       w_in_ready;
    logic       w_step;
    logic [7:0] w_j_ksa;
    logic [7:0] w_i_next;
    logic [7:0] w_j_prga;
    logic [7:0] w_ks_idx;
    logic [7:0] w_ks;
    logic       w_kidx_wrap;
    logic       w_init_wr;
    logic       w_swap_en;
    logic [7:0] w_swap_a;
    logic [7:0] w_swap_b;

    assign w_len       = (key_length > c_LEN_MAX) ? c_LEN_MAX : key_length;
    assign w_load      = (r_state == c_ST_IDLE) && start && !abort && !rst && (key_length != 9'd0);
    assign w_slot_free = !r_out_valid || out_ready;
    assign w_in_ready  = (r_state == c_ST_PRGA) && !r_phase && w_slot_free && !abort && !rst;
    assign w_step      = w_in_ready && in_valid;
    assign w_j_ksa     = r_j + r_s[r_n] + r_key[r_kidx];
    assign w_i_next    = r_i + 8'd1;
    assign w_j_prga    = r_j + r_s[w_i_next];
    assign w_ks_idx    = r_s[r_i] + r_s[r_j];
    assign w_ks        = r_s[w_ks_idx];
    assign w_kidx_wrap = ((9'(r_kidx) + 9'd1) == r_len);
    assign w_init_wr   = (r_state == c_ST_INIT);

    always_comb begin
        w_swap_en = 1'b0;
        w_swap_a  = r_n;
        w_swap_b  = w_j_ksa;
        case (r_state)
            c_ST_KSA:  w_swap_en = 1'b1;
`ifdef RC4_DROP_EN
            c_ST_DROP: begin
                w_swap_en = 1'b1;
                w_swap_a  = w_i_next;
                w_swap_b  = w_j_prga;
            end
`endif
            c_ST_PRGA: begin
                w_swap_en = w_step;
                w_swap_a  = w_i_next;
                w_swap_b  = w_j_prga;
            end
            default: ;
        endcase
    end

    // S-box and key bytes carry no reset: their contents are only meaningful after INIT/start
    always_ff @(posedge clk) begin
        if (w_init_wr) begin
            r_s[r_n] <= r_n;
        end else if (w_swap_en) begin
            r_s[w_swap_a] <= r_s[w_swap_b];
            r_s[w_swap_b] <= r_s[w_swap_a];
        end
    end

    always_ff @(posedge clk) begin
        if (w_load) begin
            for (int b = 0; b < KEY_MAX_BYTES; b++) r_key[b] <= key[8*b +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_len       <= 9'd0;
            r_kidx      <= '0;
            r_n         <= 8'd0;
            r_i         <= 8'd0;
            r_j         <= 8'd0;
            r_phase     <= 1'b0;
            r_data      <= 8'd0;
            r_busy      <= 1'b0;
            r_ks_ready  <= 1'b0;
            r_key_err   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= 8'd0;
`ifdef RC4_DROP_EN
            r_drop_cnt  <= '0;
`endif
        end else begin
            r_key_err <= 1'b0;
            if (abort) begin
                r_state     <= c_ST_IDLE;
                r_busy      <= 1'b0;
                r_ks_ready  <= 1'b0;
                r_out_valid <= 1'b0;
                r_phase     <= 1'b0;
            end else begin
                case (r_state)
                    c_ST_IDLE: begin
                        if (start) begin
                            if (key_length == 9'd0) begin
                                r_key_err <= 1'b1;
                            end else begin
                                r_len   <= w_len;
                                r_n     <= 8'd0;
                                r_busy  <= 1'b1;
                                r_state <= c_ST_INIT;
                            end
                        end
                    end
                    c_ST_INIT: begin
                        r_n <= r_n + 8'd1;
                        if (r_n == 8'hFF) begin
                            r_j     <= 8'd0;
                            r_kidx  <= '0;
                            r_state <= c_ST_KSA;
                        end
                    end
                    c_ST_KSA: begin
                        r_n    <= r_n + 8'd1;
                        r_j    <= w_j_ksa;
                        r_kidx <= w_kidx_wrap ? '0 : r_kidx + 1'b1;
                        if (r_n == 8'hFF) begin
                            r_i <= 8'd0;
                            r_j <= 8'd0;
`ifdef RC4_DROP_EN
                            r_drop_cnt <= '0;
                            r_state    <= c_ST_DROP;
`else
                            r_busy     <= 1'b0;
                            r_ks_ready <= 1'b1;
                            r_state    <= c_ST_PRGA;
`endif
                        end
                    end
`ifdef RC4_DROP_EN
                    c_ST_DROP: begin
                        r_i        <= w_i_next;
                        r_j        <= w_j_prga;
                        r_drop_cnt <= r_drop_cnt + 1'b1;
                        if (r_drop_cnt == c_DROP_LAST) begin
                            r_busy     <= 1'b0;
                            r_ks_ready <= 1'b1;
                            r_state    <= c_ST_PRGA;
                        end
                    end
`endif
                    c_ST_PRGA: begin
                        if (r_out_valid && out_ready) r_out_valid <= 1'b0;
                        if (w_step) begin
                            r_data  <= in_data;
                            r_i     <= w_i_next;
                            r_j     <= w_j_prga;
                            r_phase <= 1'b1;
                        end else if (r_phase) begin
                            r_out_data  <= r_data ^ w_ks;
                            r_out_valid <= 1'b1;
                            r_phase     <= 1'b0;
                        end
                    end
                    default: r_state <= c_ST_IDLE;
                endcase
            end
        end
    end

    assign busy      = r_busy;
    assign ks_ready  = r_ks_ready;
    assign key_err   = r_key_err;
    assign in_ready  = w_in_ready;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_rc4_stream_xor.sv
`default_nettype none
// ============================================================================
// Module   : tb_rc4_stream_xor
// Brief    : Scoreboard bench for rc4_stream_xor (known-answer vectors,
//            backpressure, key_err, length clamp, abort).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rc4_stream_xor;

    localparam int c_KMB    = 16;
    localparam int c_DROP_N = 768;
`ifdef RC4_DROP_EN
    localparam bit c_DROP = 1'b1;
    localparam int c_READY_EDGE = 513 + c_DROP_N;
`else
    localparam bit c_DROP = 1'b0;
    localparam int c_READY_EDGE = 513;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic                 abort;
    logic [c_KMB*8-1:0]   key;
    logic [8:0]           key_length;
    logic                 busy;
    logic                 ks_ready;
    logic                 key_err;
    logic [7:0]           in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic [7:0]           out_data;
    logic                 out_valid;
    logic                 out_ready;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] sb_q [$];
    logic [7:0] in_bytes  [64];
    logic [7:0] exp_bytes [64];
    logic [7:0] m_ks      [64];

    rc4_stream_xor #(.KEY_MAX_BYTES(c_KMB), .DROP_N(c_DROP_N)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .key        (key),
        .key_length (key_length),
        .busy       (busy),
        .ks_ready   (ks_ready),
        .key_err    (key_err),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] str_key(input string s);
        logic [127:0] k = '0;
        for (int x = 0; x < s.len(); x++) k[8*x +: 8] = s[x];
        return k;
    endfunction

    task automatic load_str(input string s);
        for (int x = 0; x < s.len(); x++) in_bytes[x] = s[x];
    endtask

    // Reference RC4: KSA, then 'skip' discarded bytes, then n keystream bytes into m_ks
    task automatic rc4_model(input logic [127:0] k, input int len, input int skip, input int n);
        logic [7:0] s [256];
        logic [7:0] t;
        int i, j;
        for (int x = 0; x < 256; x++) s[x] = 8'(x);
        j = 0;
        for (int x = 0; x < 256; x++) begin
            j = (j + int'(s[x]) + int'(k[8*(x % len) +: 8])) % 256;
            t = s[x]; s[x] = s[j]; s[j] = t;
        end
        i = 0;
        j = 0;
        for (int x = 0; x < skip + n; x++) begin
            i = (i + 1) % 256;
            j = (j + int'(s[i])) % 256;
            t = s[i]; s[i] = s[j]; s[j] = t;
            if (x >= skip) m_ks[x - skip] = s[(int'(s[i]) + int'(s[j])) % 256];
        end
    endtask

    task automatic fill_exp(input logic [127:0] k, input int len, input int n,
                            input logic [127:0] v, input bit use_model);
        if (use_model || c_DROP) begin
            rc4_model(k, len, c_DROP ? c_DROP_N : 0, n);
            for (int x = 0; x < n; x++) exp_bytes[x] = in_bytes[x] ^ m_ks[x];
        end else begin
            for (int x = 0; x < n; x++) exp_bytes[x] = v[8*(n-1-x) +: 8];
        end
    endtask

    task automatic start_key(input logic [127:0] k, input logic [8:0] len, input bit wait_rdy);
        int cyc;
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b1;
        key = k;
        key_length = len;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        if (wait_rdy) begin
            while (!ks_ready && cyc < 3000) begin
                if (cyc == 5) check("busy_setup", busy, 1);
                @(negedge clk);
                cyc++;
            end
            check("ks_ready_edge", cyc + 1, c_READY_EDGE);
            check("busy_ready", busy, 0);
        end
    endtask

    task automatic run_stream(input int n, input bit rand_ready, input string tag);
        int         sent = 0;
        int         recv = 0;
        int         cyc = 0;
        bit         prev_stall = 1'b0;
        logic [7:0] prev_data = 8'h00;
        sb_q.delete();
        while ((sent < n || recv < n) && cyc < 1000) begin
            @(negedge clk);
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            in_valid  = (sent < n);
            in_data   = (sent < n) ? in_bytes[sent] : 8'h00;
            #1;
            if (prev_stall) begin
                check({tag, "_hold_valid"}, out_valid, 1);
                check({tag, "_hold_data"}, out_data, prev_data);
            end
            if (in_valid && in_ready) begin
                sb_q.push_back(exp_bytes[sent]);
                sent++;
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) check({tag, "_sb_size"}, sb_q.size(), 1);
                else check({tag, "_data"}, out_data, sb_q.pop_front());
                recv++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            cyc++;
        end
        in_valid = 1'b0;
        check({tag, "_count"}, recv, n);
        @(negedge clk);
        #1;
        check({tag, "_no_extra"}, out_valid, 0);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [127:0] k;
        rst = 1'b1; start = 1'b0; abort = 1'b0; key = '0; key_length = 9'd0;
        in_data = 8'h00; in_valid = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_ks_ready", ks_ready, 0);
        check("rst_key_err", key_err, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        rst = 1'b0;

        // Known-answer "Key" / "Plaintext"
        load_str("Plaintext");
        fill_exp(str_key("Key"), 3, 9, 72'hBBF316E8D940AF0AD3, 1'b0);
        start_key(str_key("Key"), 9'd3, 1'b1);
        run_stream(9, 1'b0, "t1");

        // Known-answer "Secret" / "Attack at dawn"
        load_str("Attack at dawn");
        fill_exp(str_key("Secret"), 6, 14, 112'h45A01F645FC35B383552544B9BF5, 1'b0);
        start_key(str_key("Secret"), 9'd6, 1'b1);
        run_stream(14, 1'b0, "t2");

        // Key 01..05, zero plaintext, random backpressure
        for (int x = 0; x < 16; x++) in_bytes[x] = 8'h00;
        fill_exp(128'h0504030201, 5, 16, 128'hb2396305f03dc027ccc3524a0a1118a8, 1'b0);
        start_key(128'h0504030201, 9'd5, 1'b1);
        run_stream(16, 1'b1, "t3");

        // Zero length key: one-cycle key_err, engine stays idle
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b1;
        key_length = 9'd0;
        @(negedge clk);
        start = 1'b0;
        check("kerr_pulse", key_err, 1);
        check("kerr_busy", busy, 0);
        @(negedge clk);
        check("kerr_clear", key_err, 0);
        check("kerr_busy2", busy, 0);

        // Oversized length clamps to the full key width
        k = {$urandom, $urandom, $urandom, $urandom};
        for (int x = 0; x < 8; x++) in_bytes[x] = 8'($urandom);
        fill_exp(k, c_KMB, 8, 128'h0, 1'b1);
        start_key(k, 9'd300, 1'b1);
        run_stream(8, 1'b1, "t4");

        // Abort during KSA
        start_key(str_key("Wiki"), 9'd4, 1'b0);
        repeat (299) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_ksa_busy", busy, 0);
        check("abort_ksa_ready", ks_ready, 0);

        // Abort and start together: nothing starts
        start = 1'b1;
        abort = 1'b1;
        key_length = 9'd4;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("abort_start_busy", busy, 0);

        // Abort in PRGA while an output byte is pending
        start_key(str_key("Wiki"), 9'd4, 1'b1);
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 8'h70;
        #1;
        check("prga_in_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("prga_out_valid", out_valid, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_prga_valid", out_valid, 0);
        check("abort_prga_ready", ks_ready, 0);

        // Restart after abort: "Wiki" / "pedia"
        load_str("pedia");
        fill_exp(str_key("Wiki"), 4, 5, 40'h1021BF0420, 1'b0);
        start_key(str_key("Wiki"), 9'd4, 1'b1);
        run_stream(5, 1'b1, "t5");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
